jpeg_quant_sched: RTL and testbench

Sequencer that quantizes one 8x8 block (64 signed DCT coefficients) by time-sharing a single `mul_31_20` sign-magnitude multiplier against a 64-entry reciprocal quantization table. It sits between the DCT output stream and the zig-zag/entropy stage. It owns operand registration, multicycle settle timing for the combinational multiplier, rounding, saturation and block framing.

---
 rtl/jpeg_quant_pkg.sv | 34 +++
 rtl/mul_31_20.sv | 24 ++
 rtl/jpeg_quant_sched.sv | 142 ++++++++++++++
 tb/tb_jpeg_quant_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_quant_pkg.sv
// Shared types and arithmetic for the JPEG coefficient quantizer.
// Holds the block/table sizes, the FSM state type and the round/saturate helper.
package jpeg_quant_pkg;

    localparam int unsigned BLK_LEN = 64;
    localparam int unsigned TBL_W   = 21;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StMul,
        StOut
    } state_e;

    // Round half up with a floor shift, then clamp to a signed out_w-bit range.
    function automatic logic signed [54:0] round_sat(input logic signed [53:0] p,
                                                     input int unsigned        shift,
                                                     input int unsigned        out_w);
        logic signed [54:0] r;
        logic signed [54:0] hi;
        logic signed [54:0] lo;
        r  = (55'(p) + (55'sd1 <<< (shift - 1))) >>> shift;
        hi = (55'sd1 <<< (out_w - 1)) - 55'sd1;
        lo = -(55'sd1 <<< (out_w - 1));
        if (r > hi) begin
            return hi;
        end
        if (r < lo) begin
            return lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_31_20.sv
// Combinational sign-magnitude multiplier: 31-bit two's-complement A times a
// 20-bit magnitude with a separate sign bit, giving a 54-bit two's-complement product.
module mul_31_20 (
    input  logic [30:0] a_i,
    input  logic [19:0] b_i,
    input  logic        sign_b_i,
    output logic [53:0] c_o
);

    logic        neg;
    logic [30:0] a_mag;
    logic [50:0] mag;
    logic [50:0] mag_s;

    // A negative sign with a zero magnitude yields {3'b111, 0}; callers must guard it.
    always_comb begin
        neg   = a_i[30] ^ sign_b_i;
        a_mag = a_i[30] ? (~a_i + 31'd1) : a_i;
        mag   = 51'(a_mag) * 51'(b_i);
        mag_s = neg ? (~mag + 51'd1) : mag;
        c_o   = {{3{neg}}, mag_s};
    end

endmodule

// File: rtl/jpeg_quant_sched.sv
// Quantizes one 8x8 block of DCT coefficients by time-sharing a single multiplier
// against a 64-entry reciprocal table, with rounding, saturation and block framing.
module jpeg_quant_sched
    import jpeg_quant_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned SHIFT   = 16,
    parameter int unsigned OUT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tbl_we,
    input  logic [5:0]       tbl_addr,
    input  logic [20:0]      tbl_data,
    input  logic             start,
    output logic             busy,
    input  logic             coef_valid,
    output logic             coef_ready,
    input  logic [30:0]      coef_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [5:0]       out_idx,
    output logic             out_last,
    output logic             done
);

    localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_e                state_q, state_d;
    logic [5:0]            idx_q, idx_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic [30:0]           a_q;
    logic [19:0]           b_q;
    logic                  sb_q;
    logic [OUT_W-1:0]      out_q;
    logic [TBL_W-1:0]      tbl_q [BLK_LEN];

    logic [53:0]           prod;
    logic signed [53:0]    p_gated;
    logic signed [54:0]    rnd;
    logic                  coef_hs;
    logic                  mul_last;
    logic                  idx_end;

    mul_31_20 u_mul (
        .a_i      (a_q),
        .b_i      (b_q),
        .sign_b_i (sb_q),
        .c_o      (prod)
    );

    assign coef_hs  = (state_q == StLoad) && coef_valid;
    assign mul_last = (state_q == StMul) && (cnt_q == CntW'(MUL_LAT - 1));
    assign idx_end  = (idx_q == 6'(BLK_LEN - 1));

    // Zero operands must give zero; the multiplier's negative-zero result is not 0.
    assign p_gated = ((a_q == '0) || (b_q == '0)) ? '0 : $signed(prod);
    assign rnd     = round_sat(p_gated, SHIFT, OUT_W);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    idx_d   = '0;
                end
            end
            StLoad: begin
                if (coef_valid) begin
                    state_d = StMul;
                    cnt_d   = '0;
                end
            end
            StMul: begin
                if (mul_last) begin
                    state_d = StOut;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StOut: begin
                if (out_ready) begin
                    if (idx_end) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = StLoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sb_q    <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (coef_hs) begin
                a_q           <= coef_data;
                {sb_q, b_q}   <= tbl_q[idx_q];
            end
            if (mul_last) begin
                out_q <= OUT_W'(rnd);
            end
        end
    end

    // Table survives reset; writes are only taken while no block is in flight.
    always_ff @(posedge clk) begin
        if (tbl_we && (state_q == StIdle)) begin
            tbl_q[tbl_addr] <= tbl_data;
        end
    end

    assign busy       = (state_q != StIdle);
    assign coef_ready = (state_q == StLoad);
    assign out_valid  = (state_q == StOut);
    assign out_last   = (state_q == StOut) && idx_end;
    assign out_data   = out_q;
    assign out_idx    = idx_q;
    assign done       = done_q;

endmodule

// File: tb/tb_jpeg_quant_sched.sv
// Randomized self-checking bench for jpeg_quant_sched against an event-level model
// that tracks the table, block progress and expected quantized values.
module tb_jpeg_quant_sched;

    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned SHIFT   = 16;
    localparam int unsigned OUT_W   = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tbl_we = 1'b0;
    logic [5:0]       tbl_addr = '0;
    logic [20:0]      tbl_data = '0;
    logic             start = 1'b0;
    logic             coef_valid = 1'b0;
    logic [30:0]      coef_data = '0;
    logic             out_ready = 1'b0;
    logic             busy, coef_ready, out_valid, out_last, done;
    logic [OUT_W-1:0] out_data;
    logic [5:0]       out_idx;

    always #5 clk = ~clk;

    jpeg_quant_sched #(
        .MUL_LAT (MUL_LAT),
        .SHIFT   (SHIFT),
        .OUT_W   (OUT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tbl_we     (tbl_we),
        .tbl_addr   (tbl_addr),
        .tbl_data   (tbl_data),
        .start      (start),
        .busy       (busy),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_data  (coef_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .done       (done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Quantized value straight from the arithmetic definition.
    function automatic longint model_q(input longint a, input logic [20:0] t);
        longint m, p, r, lim;
        m = longint'(t[19:0]);
        if (a == 0 || m == 0) return 0;
        p   = a * (t[20] ? -m : m);
        r   = (p + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        lim = longint'(1) <<< (OUT_W - 1);
        if (r > lim - 1) r = lim - 1;
        if (r < -lim) r = -lim;
        return r;
    endfunction

    // Model state
    logic [20:0] m_tbl [64];
    bit          m_busy = 0, m_want = 0, m_pend = 0, mon_en = 0, exp_ov;
    int          m_idx = 0, m_due = 0, m_done_cyc = -10, m_blk = -1, cyc = 0;
    longint      m_exp = 0;
    int          lit [5];
    logic [30:0] dir_coef [5];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                exp_ov = m_pend && (cyc >= m_due);
                chk("busy", busy, m_busy);
                chk("coef_ready", coef_ready, m_want);
                chk("out_valid", out_valid, exp_ov);
                chk("done", done, cyc == m_done_cyc);
                chk("out_last", out_last, exp_ov && (m_idx == 63));
                if (exp_ov) begin
                    chk("out_data", $signed(out_data), m_exp);
                    chk("out_idx", out_idx, m_idx);
                end
                if (rst) begin
                    m_busy = 0;
                    m_want = 0;
                    m_pend = 0;
                end else begin
                    if (!m_busy && tbl_we) m_tbl[tbl_addr] = tbl_data;
                    if (!m_busy && start) begin
                        m_busy = 1;
                        m_want = 1;
                        m_idx  = 0;
                        m_blk++;
                    end else if (m_want && coef_valid) begin
                        m_want = 0;
                        m_pend = 1;
                        m_due  = cyc + MUL_LAT + 1;
                        m_exp  = model_q(longint'($signed(coef_data)), m_tbl[m_idx]);
                    end else if (exp_ov && out_ready) begin
                        if (m_blk == 0 && m_idx < 5) begin
                            chk("literal_value", $signed(out_data), lit[m_idx]);
                        end
                        m_pend = 0;
                        if (m_idx == 63) begin
                            m_busy     = 0;
                            m_done_cyc = cyc + 1;
                        end else begin
                            m_idx++;
                            m_want = 1;
                        end
                    end
                end
            end
        end
    end

    // Driver bookkeeping
    int n_acc = 0, n_out = 0, n_done = 0;

    task automatic cycle_drive();
        @(negedge clk);
        if (coef_valid && coef_ready) n_acc++;
        if (out_valid && out_ready) n_out++;
        if (done) n_done++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [30:0] rand_coef(input int minsh);
        logic [30:0] v;
        int          sh;
        if (minsh == 0 && $urandom_range(15, 0) == 0) return 31'h4000_0000;
        v  = 31'($urandom);
        sh = int'($urandom_range(30, minsh));
        return 31'($signed(v) >>> sh);
    endfunction

    task automatic load_table(input bit rnd);
        for (int i = 0; i < 64; i++) begin
            tbl_we   = 1'b1;
            tbl_addr = 6'(i);
            if (!rnd) begin
                if (i == 2) tbl_data = {1'b1, 20'd0};
                else if (i == 3 || i == 4) tbl_data = {1'b0, 20'hFFFFF};
                else tbl_data = 21'd4096;
            end else begin
                tbl_data = {1'($urandom), ($urandom_range(7, 0) == 0) ? 20'd0 : 20'($urandom)};
            end
            cycle_drive();
        end
        tbl_we = 1'b0;
    endtask

    task automatic run_block(input bit dir, input int pv, input int pr, input int rst_at,
                             input bit stall, input bit hold_start, input int exp_cycles);
        int ncyc      = 0;
        int d0        = n_done;
        int stall_cnt = 0;
        n_acc      = 0;
        n_out      = 0;
        start      = 1'b1;
        coef_valid = 1'b0;
        out_ready  = 1'b0;
        cycle_drive();
        start  = hold_start;
        tbl_we = 1'b0;
        while (n_done == d0 && ncyc < 3000) begin
            coef_valid = int'($urandom_range(99, 0)) < pv;
            if (dir && n_acc < 5) coef_data = dir_coef[n_acc];
            else coef_data = rand_coef(dir ? 13 : 0);
            out_ready = int'($urandom_range(99, 0)) < pr;
            tbl_we    = 1'b0;
            if (stall && out_valid && out_idx == 6'd5 && stall_cnt < 10) begin
                out_ready = 1'b0;
                stall_cnt++;
                if (stall_cnt == 4) begin
                    tbl_we   = 1'b1;
                    tbl_addr = 6'd10;
                    tbl_data = 21'h00123;
                end
            end
            if (rst_at >= 0 && n_acc >= rst_at) begin
                rst = 1'b1;
                cycle_drive();
                rst        = 1'b0;
                coef_valid = 1'b0;
                out_ready  = 1'b0;
                start      = 1'b0;
                chk("busy_after_rst", busy, 0);
                chk("out_valid_after_rst", out_valid, 0);
                return;
            end
            cycle_drive();
            ncyc++;
        end
        start      = 1'b0;
        coef_valid = 1'b0;
        out_ready  = 1'b0;
        tbl_we     = 1'b0;
        chk("block_done", n_done - d0, 1);
        chk("block_outputs", n_out, 64);
        chk("block_coefs", n_acc, 64);
        if (exp_cycles > 0) chk("block_cycles", ncyc, exp_cycles);
    endtask

    initial begin
        dir_coef[0] = 31'd160;
        dir_coef[1] = 31'(-160);
        dir_coef[2] = 31'(-5);
        dir_coef[3] = 31'h3FFF_FFFF;
        dir_coef[4] = 31'h4000_0000;
        lit[0] = 10;
        lit[1] = -10;
        lit[2] = 0;
        lit[3] = 32767;
        lit[4] = -32768;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_coef_ready", coef_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        mon_en = 1'b1;

        load_table(1'b0);
        run_block(1'b1, 100, 100, -1, 1'b1, 1'b0, 0);
        run_block(1'b0, 60, 60, 20, 1'b0, 1'b0, 0);
        // Write racing with start must be used by the new block
        tbl_we   = 1'b1;
        tbl_addr = 6'd0;
        tbl_data = 21'd65536;
        run_block(1'b1, 70, 50, -1, 1'b0, 1'b1, 0);
        run_block(1'b0, 100, 100, -1, 1'b0, 1'b0, 0);
        repeat (3) cycle_drive();
        run_block(1'b0, 100, 100, -1, 1'b0, 1'b0, 64 * 4 + 1);
        load_table(1'b1);
        run_block(1'b0, 50, 50, -1, 1'b0, 1'b0, 0);
        repeat (5) cycle_drive();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
